serial_fft_power_unloader: RTL and testbench

//   Downstream stage of the serial multi-channel DFT core. Captures the per-channel re/im

---
 rtl/fft_pkg.sv | 11 +
 rtl/fft_sq_acc.sv | 41 ++++
 rtl/serial_fft_power_unloader.sv | 163 ++++++++++++++++
 tb/tb_serial_fft_power_unloader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the serial DFT power unloader.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SQ_RE = 2'd1,
        SQ_IM = 2'd2,
        SEND  = 2'd3
    } unload_state_t;

endpackage

// File: rtl/fft_sq_acc.sv
// Registered signed squarer with clear/accumulate select; holds the only multiplier
// so a DSP-mapped variant can replace it.
module fft_sq_acc #(
    parameter int unsigned S_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en_i,
    input  logic                   clr_i,
    input  logic [S_WIDTH-1:0]     x_i,
    output logic [2*S_WIDTH-1:0]   acc_o
);

    localparam int unsigned P_WIDTH = 2 * S_WIDTH;

    logic signed [P_WIDTH-1:0] x_ext_c;
    logic signed [P_WIDTH-1:0] sq_c;
    logic        [P_WIDTH-1:0] acc_q;
    logic        [P_WIDTH-1:0] acc_d;

    // A square is never negative, so the signed product reinterprets cleanly as unsigned.
    always_comb begin
        x_ext_c = {{S_WIDTH{x_i[S_WIDTH-1]}}, x_i};
        sq_c    = x_ext_c * x_ext_c;
        acc_d   = acc_q;
        if (en_i) begin
            acc_d = clr_i ? $unsigned(sq_c) : acc_q + $unsigned(sq_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/serial_fft_power_unloader.sv
// Captures a multi-channel re/im frame from the DFT core and streams re, im and
// re^2+im^2 out one channel per valid/ready beat, flagging frames dropped while busy.
module serial_fft_power_unloader
    import fft_pkg::*;
#(
    parameter int unsigned S_WIDTH = 32,
    parameter int unsigned CHANELS = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          valid_i,
    input  logic [CHANELS*S_WIDTH-1:0]    re,
    input  logic [CHANELS*S_WIDTH-1:0]    im,
    output logic                          busy,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(CHANELS)-1:0]    m_chan,
    output logic [S_WIDTH-1:0]            m_re,
    output logic [S_WIDTH-1:0]            m_im,
    output logic [2*S_WIDTH-1:0]          m_power,
    output logic                          m_last,
    output logic                          overrun
);

    localparam int unsigned C_WIDTH = $clog2(CHANELS);
    localparam int unsigned P_WIDTH = 2 * S_WIDTH;
    localparam logic [C_WIDTH-1:0] LAST_CHAN = C_WIDTH'(CHANELS - 1);

    unload_state_t        state_q, state_d;
    logic [C_WIDTH-1:0]   chan_q, chan_d;
    logic [S_WIDTH-1:0]   re_q [CHANELS];
    logic [S_WIDTH-1:0]   im_q [CHANELS];
    logic [S_WIDTH-1:0]   m_re_q, m_re_d;
    logic [S_WIDTH-1:0]   m_im_q, m_im_d;
    logic                 busy_q, busy_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic                 overrun_q, overrun_d;

    logic                 accept_c;
    logic                 transfer_c;
    logic                 sq_en_c;
    logic                 sq_clr_c;
    logic [S_WIDTH-1:0]   sq_x_c;
    logic [P_WIDTH-1:0]   acc_c;

    // Next-state, squarer control and output-register next values.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        m_re_d     = m_re_q;
        m_im_d     = m_im_q;
        overrun_d  = overrun_q;
        sq_en_c    = 1'b0;
        sq_clr_c   = 1'b0;
        sq_x_c     = re_q[chan_q];
        transfer_c = m_valid_q && m_ready;
        accept_c   = valid_i && ((state_q == IDLE) ||
                                 ((state_q == SEND) && m_last_q && m_ready));

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    chan_d  = '0;
                    state_d = SQ_RE;
                end
            end
            SQ_RE: begin
                sq_en_c  = 1'b1;
                sq_clr_c = 1'b1;
                state_d  = SQ_IM;
            end
            SQ_IM: begin
                sq_en_c = 1'b1;
                sq_x_c  = im_q[chan_q];
                m_re_d  = re_q[chan_q];
                m_im_d  = im_q[chan_q];
                state_d = SEND;
            end
            SEND: begin
                if (transfer_c) begin
                    if (!m_last_q) begin
                        chan_d  = chan_q + C_WIDTH'(1);
                        state_d = SQ_RE;
                    end else if (accept_c) begin
                        chan_d  = '0;
                        state_d = SQ_RE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A frame arriving outside the accept window is lost; the in-flight one continues.
        if (valid_i && !accept_c) begin
            overrun_d = 1'b1;
        end

        busy_d    = (state_d != IDLE);
        m_valid_d = (state_d == SEND);
        m_last_d  = (state_d == SEND) && (chan_d == LAST_CHAN);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            m_re_q    <= '0;
            m_im_q    <= '0;
            busy_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            m_re_q    <= m_re_d;
            m_im_q    <= m_im_d;
            busy_q    <= busy_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            overrun_q <= overrun_d;
        end
    end

    // Frame capture: the core presents re/im for a single cycle only.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < CHANELS; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (accept_c) begin
            for (int i = 0; i < CHANELS; i++) begin
                re_q[i] <= re[i*S_WIDTH +: S_WIDTH];
                im_q[i] <= im[i*S_WIDTH +: S_WIDTH];
            end
        end
    end

    fft_sq_acc #(
        .S_WIDTH (S_WIDTH)
    ) u_sq_acc (
        .clk   (clk),
        .rstn  (rstn),
        .en_i  (sq_en_c),
        .clr_i (sq_clr_c),
        .x_i   (sq_x_c),
        .acc_o (acc_c)
    );

    assign busy    = busy_q;
    assign m_valid = m_valid_q;
    assign m_chan  = chan_q;
    assign m_re    = m_re_q;
    assign m_im    = m_im_q;
    assign m_power = acc_c;
    assign m_last  = m_last_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_serial_fft_power_unloader.sv
// Scoreboard bench for serial_fft_power_unloader: randomized frames against an arithmetic model.
module tb_serial_fft_power_unloader;

    localparam int unsigned SW  = 32;
    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = $clog2(NCH);
    localparam int unsigned PW  = 2 * SW;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              valid_i = 1'b0;
    logic              m_ready = 1'b0;
    logic [NCH*SW-1:0] re_bus = '0;
    logic [NCH*SW-1:0] im_bus = '0;
    logic              busy, m_valid, m_last, overrun;
    logic [CW-1:0]     m_chan;
    logic [SW-1:0]     m_re, m_im;
    logic [PW-1:0]     m_power;

    serial_fft_power_unloader #(.S_WIDTH(SW), .CHANELS(NCH)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .re(re_bus), .im(im_bus),
        .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan),
        .m_re(m_re), .m_im(m_im), .m_power(m_power), .m_last(m_last), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   chan;
        logic [SW-1:0] re;
        logic [SW-1:0] im;
        logic [PW-1:0] power;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            beats_left = 0;
    int            ready_mode = 1;
    logic [SW-1:0] fr_re [NCH];
    logic [SW-1:0] fr_im [NCH];

    logic          hold_prev = 1'b0;
    logic [CW-1:0] prev_chan;
    logic [SW-1:0] prev_re, prev_im;
    logic [PW-1:0] prev_power;
    logic          prev_last;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // |X|^2 from plain 64-bit arithmetic on the sign-extended components.
    function automatic logic [PW-1:0] model_power(input logic [SW-1:0] r, input logic [SW-1:0] i);
        longint sr, si;
        sr = longint'(signed'(r));
        si = longint'(signed'(i));
        return PW'(sr * sr + si * si);
    endfunction

    task automatic load_bus();
        for (int c = 0; c < NCH; c++) begin
            re_bus[c*SW +: SW] = fr_re[c];
            im_bus[c*SW +: SW] = fr_im[c];
        end
    endtask

    task automatic push_frame();
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back('{chan: c, re: fr_re[c], im: fr_im[c],
                              power: model_power(fr_re[c], fr_im[c]), last: (c == NCH - 1)});
        end
        beats_left += NCH;
    endtask

    function automatic logic [SW-1:0] rand_word();
        int unsigned k;
        k = $urandom % 8;
        if (k == 0) return 32'h8000_0000;
        if (k == 1) return 32'h7fff_ffff;
        return SW'($urandom);
    endfunction

    task automatic rand_frame();
        for (int c = 0; c < NCH; c++) begin
            fr_re[c] = rand_word();
            fr_im[c] = rand_word();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive valid_i for one cycle starting at posedge+1; the model knows if it is accepted.
    task automatic issue(input bit accepted);
        load_bus();
        valid_i = 1'b1;
        if (accepted) push_frame();
        step();
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (beats_left != 0 && k < budget) begin
            step();
            k++;
        end
        if (beats_left != 0) check("idle_timeout", 64'(beats_left), 64'd0);
    endtask

    task automatic wait_valid(input bit need_last);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (m_valid && (!need_last || m_last)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 64'd0, 64'd1);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = (($urandom % 4) != 0);
            1:       m_ready = 1'b1;
            default: m_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    always @(negedge clk) begin
        beat_t e;
        if (!rstn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_chan",  64'(m_chan),  64'(prev_chan));
                check("stall_re",    64'(m_re),    64'(prev_re));
                check("stall_im",    64'(m_im),    64'(prev_im));
                check("stall_power", m_power,      prev_power);
                check("stall_last",  64'(m_last),  64'(prev_last));
            end
            if (m_valid && m_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat: unexpected beat chan=%0d power=%h, expected none", m_chan, m_power);
                end else begin
                    e = exp_q.pop_front();
                    beats_left--;
                    if (m_chan !== CW'(e.chan) || m_re !== e.re || m_im !== e.im ||
                        m_power !== e.power || m_last !== e.last) begin
                        n_err++;
                        $display("FAIL beat: got chan=%0d re=%h im=%h power=%h last=%b, expected chan=%0d re=%h im=%h power=%h last=%b",
                                 m_chan, m_re, m_im, m_power, m_last, e.chan, e.re, e.im, e.power, e.last);
                    end
                end
            end
            hold_prev  = m_valid && !m_ready;
            prev_chan  = m_chan;
            prev_re    = m_re;
            prev_im    = m_im;
            prev_power = m_power;
            prev_last  = m_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state.
        repeat (3) step();
        rstn = 1'b1;
        @(negedge clk);
        check("rst_valid",   64'(m_valid), 64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_chan",    64'(m_chan),  64'd0);
        check("rst_last",    64'(m_last),  64'd0);
        check("rst_re",      64'(m_re),    64'd0);
        check("rst_im",      64'(m_im),    64'd0);
        check("rst_power",   m_power,      64'd0);

        // Basic frame with latency: re={-5,3}, im={12,4} as {chan1,chan0}.
        ready_mode = 1;
        step();
        fr_re[0] = 32'd3;  fr_re[1] = 32'hffff_fffb;
        fr_im[0] = 32'd4;  fr_im[1] = 32'd12;
        load_bus();
        valid_i = 1'b1;
        push_frame();
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("latency_valid", 64'(m_valid), 64'(exp_v[k]));
            if (k == 2) check("basic_power0", m_power, 64'd25);
            if (k == 5) begin
                check("basic_power1", m_power, 64'd169);
                check("basic_last",   64'(m_last), 64'd1);
            end
        end
        step();
        wait_idle(50);
        check("basic_busy_done", 64'(busy), 64'd0);

        // Extremes: most negative value on every component.
        for (int c = 0; c < NCH; c++) begin
            fr_re[c] = 32'h8000_0000;
            fr_im[c] = 32'h8000_0000;
        end
        issue(1'b1);
        wait_valid(1'b0);
        check("extreme_power", m_power, 64'h8000_0000_0000_0000);
        wait_idle(50);

        // Backpressure on chan0 for five cycles.
        ready_mode = 2;
        step();
        rand_frame();
        issue(1'b1);
        wait_valid(1'b0);
        repeat (5) @(negedge clk);
        check("bp_valid", 64'(m_valid), 64'd1);
        check("bp_chan",  64'(m_chan),  64'd0);
        step();
        ready_mode = 1;
        wait_idle(50);

        // Back-to-back: new frame coincident with the last transfer.
        rand_frame();
        issue(1'b1);
        wait_valid(1'b1);
        rand_frame();
        load_bus();
        valid_i = 1'b1;
        push_frame();
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b2b_valid", 64'(m_valid), 64'(k == 2));
            if (k == 2) check("b2b_chan", 64'(m_chan), 64'd0);
        end
        check("b2b_overrun", 64'(overrun), 64'd0);
        step();
        wait_idle(50);

        // Overrun: a second frame two cycles after the first is dropped.
        check("overrun_pre", 64'(overrun), 64'd0);
        rand_frame();
        issue(1'b1);
        step();
        rand_frame();
        issue(1'b0);
        wait_idle(50);
        check("overrun_set", 64'(overrun), 64'd1);

        // Randomized frames under random backpressure.
        ready_mode = 0;
        for (int f = 0; f < 40; f++) begin
            rand_frame();
            repeat ($urandom % 4) step();
            issue(1'b1);
            wait_idle(300);
        end
        check("overrun_sticky", 64'(overrun), 64'd1);

        // Reset in the middle of a stalled SEND.
        ready_mode = 2;
        step();
        rand_frame();
        issue(1'b1);
        wait_valid(1'b0);
        step();
        rstn = 1'b0;
        exp_q.delete();
        beats_left = 0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_valid",   64'(m_valid), 64'd0);
        check("midrst_busy",    64'(busy),    64'd0);
        check("midrst_overrun", 64'(overrun), 64'd0);
        check("midrst_power",   m_power,      64'd0);
        ready_mode = 1;
        step();
        rand_frame();
        issue(1'b1);
        wait_idle(50);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
